// File: rtl/puf_eval_ctrl_if.sv
// Result stream of the PUF evaluation controller: voted response, stability flags
// and the originating challenge, offered on a valid/ready handshake.
interface puf_eval_ctrl_if #(
   parameter int C_LENGTH = 8,
   parameter int RESP_W   = 7
);
   logic                resp_valid;
   logic                resp_ready;
   logic [RESP_W-1:0]   resp_data;
   logic [RESP_W-1:0]   resp_unstable;
   logic [C_LENGTH-1:0] resp_chal;

   modport master (
      output resp_valid, resp_data, resp_unstable, resp_chal,
      input  resp_ready
   );

   modport slave (
      input  resp_valid, resp_data, resp_unstable, resp_chal,
      output resp_ready
   );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Arbiter PUF evaluation front end: fires each challenge N_EVAL times, majority-votes
// the synchronised response bits and publishes the result with per-bit instability flags.
module puf_eval_ctrl #(
   parameter int                  C_LENGTH  = 8,
   parameter int                  RESP_W    = 7,
   parameter int                  N_EVAL    = 5,
   parameter int                  SETTLE    = 4,
   parameter logic [C_LENGTH-1:0] LFSR_TAPS = 8'hB8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                use_lfsr,
   input  logic [C_LENGTH-1:0] chal_in,
   input  logic                seed_load,
   input  logic [C_LENGTH-1:0] seed,
   output logic                puf_pulse,
   output logic [C_LENGTH-1:0] puf_challenge,
   input  logic [RESP_W-1:0]   puf_response,
   output logic                busy,
   puf_eval_ctrl_if.master     rsp
);

   localparam int OW = $clog2(N_EVAL + 1);
   localparam int RW = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE - 1);
   localparam logic [RW-1:0] ROUND_LAST = RW'(N_EVAL - 1);
   localparam logic [OW-1:0] VOTE_HALF  = OW'(N_EVAL / 2);
   localparam logic [OW-1:0] VOTE_ALL   = OW'(N_EVAL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FIRE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [RW-1:0]               round_q, round_d;
   logic [C_LENGTH-1:0]         chal_q, chal_d;
   logic [C_LENGTH-1:0]         lfsr_q, lfsr_d;
   logic [RESP_W-1:0][OW-1:0]   ones_q, ones_d;
   logic [RESP_W-1:0]           sync_meta_q, sync_meta_d;
   logic [RESP_W-1:0]           sync_q, sync_d;
   logic                        valid_q, valid_d;
   logic [RESP_W-1:0]           data_q, data_d;
   logic [RESP_W-1:0]           unst_q, unst_d;
   logic [C_LENGTH-1:0]         rchal_q, rchal_d;

   logic [RESP_W-1:0]           vote_bit;
   logic [RESP_W-1:0]           unstable_bit;
   logic [C_LENGTH-1:0]         lfsr_step;

   genvar gi;
   generate
      for (gi = 0; gi < RESP_W; gi++) begin : g_vote
         assign vote_bit[gi]     = (ones_q[gi] > VOTE_HALF);
         assign unstable_bit[gi] = (ones_q[gi] != '0) && (ones_q[gi] != VOTE_ALL);
      end
   endgenerate

   assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         round_q     <= '0;
         chal_q      <= '0;
         lfsr_q      <= C_LENGTH'(1);
         ones_q      <= '0;
         sync_meta_q <= '0;
         sync_q      <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         unst_q      <= '0;
         rchal_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         round_q     <= round_d;
         chal_q      <= chal_d;
         lfsr_q      <= lfsr_d;
         ones_q      <= ones_d;
         sync_meta_q <= sync_meta_d;
         sync_q      <= sync_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         unst_q      <= unst_d;
         rchal_q     <= rchal_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      round_d     = round_q;
      chal_d      = chal_q;
      lfsr_d      = lfsr_q;
      ones_d      = ones_q;
      valid_d     = valid_q;
      data_d      = data_q;
      unst_d      = unst_q;
      rchal_d     = rchal_q;
      sync_meta_d = puf_response;
      sync_d      = sync_meta_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               chal_d  = use_lfsr ? lfsr_q : chal_in;
               ones_d  = '0;
               round_d = '0;
               cnt_d   = '0;
               state_d = S_ARM;
            end else if (seed_load) begin
               lfsr_d = (seed == '0) ? C_LENGTH'(1) : seed;
            end
         end
         S_ARM: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_FIRE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIRE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            for (int i = 0; i < RESP_W; i++) begin
               ones_d[i] = ones_q[i] + OW'(sync_q[i]);
            end
            round_d = round_q + 1'b1;
            state_d = (round_q == ROUND_LAST) ? S_DONE : S_ARM;
         end
         S_DONE: begin
            // Result registers load once on entry and then hold until accepted.
            if (!valid_q) begin
               valid_d = 1'b1;
               data_d  = vote_bit;
               unst_d  = unstable_bit;
               rchal_d = chal_q;
            end else if (rsp.resp_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
               if (use_lfsr) begin
                  lfsr_d = lfsr_step;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pulse and busy decode straight from the state so reset drops them at once.
   always_comb begin
      puf_pulse = (state_q == S_FIRE);
      busy      = (state_q != S_IDLE);
   end

   assign puf_challenge     = chal_q;
   assign rsp.resp_valid    = valid_q;
   assign rsp.resp_data     = data_q;
   assign rsp.resp_unstable = unst_q;
   assign rsp.resp_chal     = rchal_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: fixed and per-round PUF responses, LFSR sequencing,
// back-pressure, mid-evaluation reset and launch-pulse waveform.
module tb_puf_eval_ctrl;
   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       use_lfsr = 1'b0;
   logic [7:0] chal_in = '0;
   logic       seed_load = 1'b0;
   logic [7:0] seed = '0;
   logic       puf_pulse;
   logic [7:0] puf_challenge;
   logic [6:0] puf_response = '0;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] seq [5];
   int         pulse_idx = 0;
   int         base = 0;

   puf_eval_ctrl_if #(.C_LENGTH(8), .RESP_W(7)) rsp_if ();

   puf_eval_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .use_lfsr      (use_lfsr),
      .chal_in       (chal_in),
      .seed_load     (seed_load),
      .seed          (seed),
      .puf_pulse     (puf_pulse),
      .puf_challenge (puf_challenge),
      .puf_response  (puf_response),
      .busy          (busy),
      .rsp           (rsp_if)
   );

   always #5 clk = ~clk;

   // PUF model: each launch pulse produces the next word of the current sequence.
   always @(posedge puf_pulse) begin
      puf_response = seq[(pulse_idx - base) % 5];
      pulse_idx++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic set_seq(input logic [6:0] a, b, c, d, e);
      seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d; seq[4] = e;
      base = pulse_idx;
   endtask

   task automatic run_eval(input logic [7:0] c, input logic ul,
                           output int lat, output int pulses, output int bad_w,
                           output int bad_gap, output int chal_tog);
      logic [7:0] prev_ch;
      logic       prev_p;
      int         hirun, lowrun;
      lat = -1; pulses = 0; bad_w = 0; bad_gap = 0; chal_tog = 0;
      hirun = 0; lowrun = 0; prev_p = 1'b0;
      @(negedge clk);
      chal_in = c; use_lfsr = ul; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      prev_ch = puf_challenge;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (busy && puf_challenge != prev_ch) chal_tog++;
         prev_ch = puf_challenge;
         if (puf_pulse) begin
            if (!prev_p) begin
               pulses++;
               if (pulses > 1 && lowrun != SETTLE + 1) bad_gap++;
               hirun = 1;
            end else hirun++;
         end else begin
            if (prev_p) begin
               if (hirun != SETTLE) bad_w++;
               lowrun = 1;
            end else lowrun++;
         end
         prev_p = puf_pulse;
         if (rsp_if.resp_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic handshake(input logic with_start);
      @(negedge clk);
      rsp_if.resp_ready = 1'b1;
      start = with_start;
      @(posedge clk);
      #1 rsp_if.resp_ready = 1'b0;
      start = 1'b0;
      check_eq("hs_valid_drop", 32'(rsp_if.resp_valid), 32'd0);
      check_eq("hs_idle", 32'(busy), 32'd0);
   endtask

   int lat, pulses, bad_w, bad_gap, chal_tog;
   int stall_bad;
   logic [6:0] snap_data, snap_unst;
   logic [7:0] snap_chal;

   initial begin
      rsp_if.resp_ready = 1'b0;
      set_seq(7'h55, 7'h55, 7'h55, 7'h55, 7'h55);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      check_eq("rst_valid", 32'(rsp_if.resp_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_pulse", 32'(puf_pulse), 32'd0);
      check_eq("rst_chal", 32'(puf_challenge), 32'h00);
      check_eq("rst_data", 32'(rsp_if.resp_data), 32'h00);

      // Fixed response, external challenge, waveform and latency.
      set_seq(7'h55, 7'h55, 7'h55, 7'h55, 7'h55);
      run_eval(8'hA3, 1'b0, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t1_latency", 32'(lat), 32'd46);
      check_eq("t1_pulses", 32'(pulses), 32'd5);
      check_eq("t1_pulse_width_errs", 32'(bad_w), 32'd0);
      check_eq("t1_pulse_gap_errs", 32'(bad_gap), 32'd0);
      check_eq("t1_chal_toggles", 32'(chal_tog), 32'd0);
      check_eq("t1_data", 32'(rsp_if.resp_data), 32'h55);
      check_eq("t1_unstable", 32'(rsp_if.resp_unstable), 32'h00);
      check_eq("t1_resp_chal", 32'(rsp_if.resp_chal), 32'hA3);
      check_eq("t1_puf_chal", 32'(puf_challenge), 32'hA3);
      handshake(1'b0);

      // Bit 0 votes 1,1,0,1,0: majority 1, flagged unstable.
      set_seq(7'h55, 7'h55, 7'h54, 7'h55, 7'h54);
      run_eval(8'h17, 1'b0, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t2_data", 32'(rsp_if.resp_data), 32'h55);
      check_eq("t2_unstable", 32'(rsp_if.resp_unstable), 32'h01);
      handshake(1'b0);

      // Zero seed loads 1; LFSR walks 01, B8, 5C.
      @(negedge clk);
      seed = 8'h00; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      set_seq(7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A);
      run_eval(8'hFF, 1'b1, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t3_chal0", 32'(rsp_if.resp_chal), 32'h01);
      check_eq("t3_data0", 32'(rsp_if.resp_data), 32'h2A);
      handshake(1'b0);
      run_eval(8'hFF, 1'b1, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t3_chal1", 32'(rsp_if.resp_chal), 32'hB8);
      handshake(1'b0);
      run_eval(8'hFF, 1'b1, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t3_chal2", 32'(rsp_if.resp_chal), 32'h5C);

      // Back-pressure for 20 cycles with start pulses: nothing may move.
      snap_data = rsp_if.resp_data;
      snap_unst = rsp_if.resp_unstable;
      snap_chal = rsp_if.resp_chal;
      stall_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = (i % 4 == 0);
         @(posedge clk);
         #1;
         if (!rsp_if.resp_valid || !busy || puf_pulse ||
             rsp_if.resp_data != snap_data || rsp_if.resp_unstable != snap_unst ||
             rsp_if.resp_chal != snap_chal || puf_challenge != 8'h5C) stall_bad++;
      end
      start = 1'b0;
      check_eq("t4_stall_changes", 32'(stall_bad), 32'd0);
      handshake(1'b1);
      run_eval(8'hFF, 1'b1, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t4_lfsr_one_step", 32'(rsp_if.resp_chal), 32'h2E);
      handshake(1'b0);

      // Reset during the second FIRE phase, then a clean evaluation.
      set_seq(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      @(negedge clk);
      chal_in = 8'h3C; use_lfsr = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check_eq("t5_pulse_before_rst", 32'(puf_pulse), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t5_pulse_in_rst", 32'(puf_pulse), 32'd0);
      check_eq("t5_busy_in_rst", 32'(busy), 32'd0);
      @(negedge clk) rst = 1'b0;
      set_seq(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      run_eval(8'h3C, 1'b0, lat, pulses, bad_w, bad_gap, chal_tog);
      check_eq("t5_latency", 32'(lat), 32'd46);
      check_eq("t5_data", 32'(rsp_if.resp_data), 32'h00);
      check_eq("t5_unstable", 32'(rsp_if.resp_unstable), 32'h00);
      check_eq("t5_resp_chal", 32'(rsp_if.resp_chal), 32'h3C);
      handshake(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
